// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM state encoding, data width and
// the baud divider calculation.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Receiver FSM states; PARITY is only reachable when UART_RXD_PARITY_EN is defined.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] BREAK  = 3'd4;
    localparam logic [2:0] PARITY = 3'd5;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int step;
        step = baud * oversample;
        return (clk_freq + step / 2) / step;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, restartable by clr.
// Shared between the UART receiver and transmitter.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rxd.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, 16x oversampled majority vote,
// valid/ready holding register. Define UART_RXD_PARITY_EN to add an even-parity bit.
module uart_rxd
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                   SYS_CLK,
    input  logic                   RST,
    input  logic                   Rxd,
    output logic [UART_DATA_W-1:0] data_out,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   parity_err
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam logic [SW-1:0] S_LO  = SW'(M - 1);
    localparam logic [SW-1:0] S_MID = SW'(M);
    localparam logic [SW-1:0] S_HI  = SW'(M + 1);
    localparam logic [SW-1:0] S_TOP = SW'(OVERSAMPLE - 1);

    logic                   sync1, rxd_s, rxd_q;
    logic [2:0]             state;
    logic [SW-1:0]          scnt, scnt_next;
    logic [2:0]             bcnt;
    logic [UART_DATA_W-1:0] shreg;
    logic [1:0]             votes;
    logic                   par_bad;
    logic                   tick, start_edge, at_vote, vote, deliver;

    // NOTE: the synchronizer resets to the idle line level so leaving reset never looks like a start edge.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
            rxd_q <= 1'b1;
        end else begin
            sync1 <= Rxd;
            rxd_s <= sync1;
            rxd_q <= rxd_s;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (SYS_CLK),
        .rst  (RST),
        .clr  (start_edge),
        .tick (tick)
    );

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        scnt_next  = (scnt == S_TOP) ? '0 : scnt + 1'b1;
        start_edge = (state == IDLE) && rxd_q && !rxd_s;
        at_vote    = tick && (scnt_next == S_HI) && (state != IDLE) && (state != BREAK);
        vote       = (votes[1] & votes[0]) | (votes[1] & rxd_s) | (votes[0] & rxd_s);
        deliver    = at_vote && (state == STOP) && vote && !par_bad;
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state     <= IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            votes     <= '0;
            par_bad   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RXD_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RXD_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (tick && state != IDLE) begin
                scnt <= scnt_next;
                if (scnt_next == S_LO || scnt_next == S_MID) begin
                    votes <= {votes[0], rxd_s};
                end
            end
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state   <= START;
                        scnt    <= '0;
                        bcnt    <= '0;
                        par_bad <= 1'b0;
                    end
                end
                START: begin
                    if (at_vote) state <= vote ? IDLE : DATA;
                end
                DATA: begin
                    if (at_vote) begin
                        shreg <= {vote, shreg[UART_DATA_W-1:1]};
                        bcnt  <= bcnt + 1'b1;
                        if (bcnt == 3'd7) begin
`ifdef UART_RXD_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RXD_PARITY_EN
                PARITY: begin
                    if (at_vote) begin
                        if (vote != ^shreg) begin
                            parity_err <= 1'b1;
                            par_bad    <= 1'b1;
                        end
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (at_vote) begin
                        if (vote) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A full holding register drops the new byte unless it is being accepted this cycle.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            data_out <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    data_out <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifndef UART_RXD_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rxd.md
Name: uart_rxd

Overview:
- UART receiver, 8 data bits, LSB first, 1 stop bit, no parity by default.
- Receive-direction counterpart to the existing UART transmitter. Feeds host commands (camera register writes, capture triggers) back into the OV7670 capture design.
- Uses 16x oversampling with majority-vote bit sampling.
- Presents each received byte on a valid/ready holding register.

Parameters:
- CLK_FREQ, 50_000_000: SYS_CLK frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and ≥ 8.

Ports:
- SYS_CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous reset, active-high.
- Rxd  in  1  asynchronous serial line; idles high.
- data_out  out  8  received byte; valid while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts the byte when rx_valid and rx_ready are both 1.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte dropped because the holding register was full.
- parity_err  out  1  one-cycle pulse. Tied 0 unless PARITY_EN is defined.

Behaviour:
- Reset (RST=1 at a SYS_CLK edge): all outputs 0, data_out=0x00, FSM=IDLE, counters 0, synchronizer flops set to 1. Reset mid-frame abandons the frame immediately; no error pulses are raised.
- Synchronizer: Rxd passes through 2 flops to give rxd_s. Falling-edge detection uses one further registered copy.
- Tick generator:
  - DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)); 27 at the defaults.
  - tick pulses 1 cycle every DIV cycles.
  - Counter restarts at 0 when a start edge is detected, so sampling phase aligns to the edge.
- Sample counter scnt runs 0..OVERSAMPLE-1 on ticks. The bit value is the majority of rxd_s at scnt = M-1, M, M+1, where M = OVERSAMPLE/2.
- FSM states IDLE, START, DATA, STOP, BREAK:
  - IDLE: a falling edge on rxd_s moves to START, with scnt and the tick counter cleared.
  - START: at scnt=M+1 the start bit is voted. Vote 0 moves to DATA; vote 1 is treated as a glitch and returns to IDLE silently.
  - DATA: at scnt=M+1 the bit is voted and shifted into shreg[7] with a right shift, so the first-received bit ends in bit 0. After 8 bits, move to STOP.
  - STOP: at scnt=M+1 the stop bit is voted.
    - Vote 1: deliver the byte (see Output handshake), go to IDLE.
    - Vote 0: frame_err pulses, byte discarded, go to BREAK.
    - Leaving at mid-stop-bit allows back-to-back frames with zero idle time.
  - BREAK: wait until rxd_s=1, then go to IDLE. This prevents a held-low line from restarting reception repeatedly.
- Output handshake:
  - rx_valid rises on the cycle after the stop-bit vote. That is 9.5 bit times plus ≤4 SYS_CLK after the start edge.
  - Delivery while rx_valid=0: load data_out, set rx_valid=1.
  - Delivery while rx_valid=1 and rx_ready=1 in the same cycle: the new byte is loaded and rx_valid stays 1.
  - Delivery while rx_valid=1 and rx_ready=0: the new byte is dropped, overrun pulses, data_out is unchanged.
  - Accept with no delivery: rx_valid clears next cycle.
  - data_out must not change while rx_valid=1 and rx_ready=0.

Optional Feature:
- Macro: UART_RXD_PARITY_EN.
- Defined:
  - New state PARITY sits between DATA and STOP and votes one even-parity bit.
  - Mismatch: parity_err pulses at the parity vote, byte is discarded. The FSM still samples the stop bit (frame_err applies as normal), then goes to IDLE or BREAK.
  - Frame length is 11 bit times.
- Not defined: the PARITY state and parity logic are absent, parity_err is constant 0, and the frame is 10 bit times.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK, PARITY);
  - a function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE;
  - constant UART_DATA_W = 8.
- Sub-module uart_baud_tick: parameterized divider with a sync clear input, producing tick. It is reusable by the transmitter.

Test Plan (defaults; DIV=27, bit=432 cycles):
- Send 0xA5 8N1 with rx_ready=1 → rx_valid asserted for exactly 1 cycle with data_out=0xA5 roughly 4104 cycles after the start edge; frame_err=overrun=0.
- Rxd low for 100 cycles, then high → no rx_valid, no error; FSM back in IDLE. A following 0x3C is received correctly.
- Send 0x3C with stop bit 0, then hold Rxd low for 2000 cycles → frame_err pulses once, rx_valid stays 0, FSM waits in BREAK. After the line returns high, 0x55 is received correctly.
- Back-to-back 0x00 then 0xFF, rx_ready=0 → data_out=0x00 held, overrun pulses once at the second stop vote. Raising rx_ready then clears rx_valid the next cycle.
- Pulse RST for 1 cycle after bit 3 of 0x81 → all outputs 0 the next cycle, no pulses. A subsequent full 0x81 frame is received correctly.
- With UART_RXD_PARITY_EN: 0x07 with parity bit 1 → delivered. 0x07 with parity bit 0 → parity_err pulses once, rx_valid stays 0.
